// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: FSM encoding, 100 MHz
// default timings, stopwatch button indices and the per-channel event bundle.
package btn_pkg;

    typedef enum logic {
        REL = 1'b0,
        PRS = 1'b1
    } btn_state_e;

    localparam int unsigned DEB_CLK_100M  = 1_000_000;    // 10 ms
    localparam int unsigned LONG_CLK_100M = 200_000_000;  // 2 s

    localparam int unsigned BTN_START = 0;
    localparam int unsigned BTN_STOP  = 1;

    typedef struct packed {
        logic level;
        logic press;
        logic rel;
        logic lng;
    } btn_evt_t;

    function automatic int unsigned btn_cnt_w(input int unsigned long_clk);
        return $clog2(long_clk + 1);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// Single-button conditioner: 2-flop synchroniser, stability counter, REL/PRS FSM.
// Long-press hold counter is built only when BTN_LONGPRESS_EN is defined.
import btn_pkg::*;

module btn_debounce_ch #(
    parameter int unsigned DEB_CLK  = DEB_CLK_100M,
    parameter int unsigned LONG_CLK = LONG_CLK_100M,
    parameter int unsigned CNT_W    = btn_cnt_w(LONG_CLK)
) (
    input  logic     i_Clk,
    input  logic     i_Rst,
    input  logic     i_Btn,
    output btn_evt_t o_Evt
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CLK - 1);

    logic [1:0]       sync_q;
    logic             sync;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             level;
    logic             differ;
    logic             long_p;

    // Idle-high reset value so a released key produces no spurious edge.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], i_Btn};
        end
    end

    assign sync   = sync_q[1];
    assign level  = (state_q == REL);
    assign differ = (sync != level);

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_q <= REL;
            cnt_q   <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    // Any sample matching the current level restarts the stability window.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        press_d = 1'b0;
        rel_d   = 1'b0;
        if (differ) begin
            if (cnt_q == DEB_LAST) begin
                cnt_d = '0;
                case (state_q)
                    REL: begin
                        state_d = PRS;
                        press_d = 1'b1;
                    end
                    PRS: begin
                        state_d = REL;
                        rel_d   = 1'b1;
                    end
                    default: state_d = REL;
                endcase
            end else if (cnt_q < DEB_LAST) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

`ifdef BTN_LONGPRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CLK - 1);
    localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_CLK);

    logic [CNT_W-1:0] hold_q, hold_d;
    logic             long_q, long_d;

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    // Counting only while PRS persists across the edge; saturation keeps one pulse per hold.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (state_q != PRS || state_d != PRS) begin
            hold_d = '0;
        end else begin
            if (hold_q == LONG_LAST) begin
                long_d = 1'b1;
            end
            if (hold_q != LONG_SAT) begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    assign long_p = long_q;
`else
    assign long_p = 1'b0;
`endif

    assign o_Evt.level = level;
    assign o_Evt.press = press_q;
    assign o_Evt.rel   = rel_q;
    assign o_Evt.lng   = long_p;

endmodule

// File: rtl/btn_debounce.sv
// Push-button group conditioner: NUM_BTN independent debounce channels.
// Define BTN_LONGPRESS_EN to enable the o_Long hold-detect pulse.
import btn_pkg::*;

module btn_debounce #(
    parameter int unsigned NUM_BTN  = 2,
    parameter int unsigned DEB_CLK  = DEB_CLK_100M,
    parameter int unsigned LONG_CLK = LONG_CLK_100M
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic [NUM_BTN-1:0] i_Btn,
    output logic [NUM_BTN-1:0] o_Level,
    output logic [NUM_BTN-1:0] o_Press,
    output logic [NUM_BTN-1:0] o_Release,
    output logic [NUM_BTN-1:0] o_Long
);

    localparam int unsigned CNT_W = $clog2(LONG_CLK + 1);

    btn_evt_t [NUM_BTN-1:0] evt;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .DEB_CLK  (DEB_CLK),
            .LONG_CLK (LONG_CLK),
            .CNT_W    (CNT_W)
        ) u_ch (
            .i_Clk (i_Clk),
            .i_Rst (i_Rst),
            .i_Btn (i_Btn[g]),
            .o_Evt (evt[g])
        );

        assign o_Level[g]   = evt[g].level;
        assign o_Press[g]   = evt[g].press;
        assign o_Release[g] = evt[g].rel;
        assign o_Long[g]    = evt[g].lng;
    end

endmodule
